// File: rtl/bus_ticket_server.sv
// Seat reservation server: check availability, hold seats while payment is pending,
// then confirm with a ticket number, release on timeout, or reject; cancels return seats in IDLE.
module bus_ticket_server #(
  parameter int CAPACITY    = 40,
  parameter int PAY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_seats,
  output logic       req_ready,
  input  logic       pay_ok,
  input  logic       cancel_valid,
  input  logic [2:0] cancel_seats,
  output logic       cancel_ack,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [7:0] ticket_id,
  output logic [5:0] seats_free,
  output logic       busy
);

  localparam logic [5:0] CAP  = 6'(CAPACITY);
  localparam logic [6:0] CAP7 = 7'(CAPACITY);
  localparam logic [7:0] TMAX = 8'(PAY_TIMEOUT - 1);

  localparam logic [1:0] RC_OK      = 2'b00;
  localparam logic [1:0] RC_SOLD    = 2'b01;
  localparam logic [1:0] RC_TIMEOUT = 2'b10;
  localparam logic [1:0] RC_INVALID = 2'b11;

  typedef enum logic [2:0] {IDLE, CHECK, HOLD, CONFIRM, RELEASE, REJECT} state_t;

  state_t     state, state_n;
  logic [2:0] req_reg;
  logic [7:0] timer, next_id;
  logic [1:0] rej_code;
  logic       accept, cancel_apply, too_many;
  logic [6:0] cancel_sum, release_sum;

  assign req_ready    = (state == IDLE) && !rst;
  assign busy         = (state != IDLE);
  assign accept       = req_valid && req_ready;
  // a request taking the edge wins; the cancel source re-presents later
  assign cancel_apply = (state == IDLE) && cancel_valid && !accept;
  assign too_many     = {4'b0, req_reg} > {1'b0, seats_free};
  assign cancel_sum   = {1'b0, seats_free} + {4'b0, cancel_seats};
  assign release_sum  = {1'b0, seats_free} + {4'b0, req_reg};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CHECK;
      CHECK:   state_n = (req_reg == 3'd0 || too_many) ? REJECT : HOLD;
      HOLD:    if (pay_ok) state_n = CONFIRM;
               else if (timer == TMAX) state_n = RELEASE;
      CONFIRM: state_n = IDLE;
      RELEASE: state_n = IDLE;
      REJECT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      seats_free <= CAP;
      next_id    <= 8'd0;
      ticket_id  <= 8'd0;
      timer      <= 8'd0;
      req_reg    <= 3'd0;
      rej_code   <= RC_OK;
      resp_valid <= 1'b0;
      resp_code  <= RC_OK;
      cancel_ack <= 1'b0;
    end else begin
      state      <= state_n;
      resp_valid <= 1'b0;
      cancel_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) req_reg <= req_seats;
          else if (cancel_apply) begin
            seats_free <= (cancel_sum > CAP7) ? CAP : cancel_sum[5:0];
            cancel_ack <= 1'b1;
          end
        end
        CHECK: begin
          if (req_reg == 3'd0) rej_code <= RC_INVALID;
          else if (too_many)   rej_code <= RC_SOLD;
          else begin
            seats_free <= seats_free - {3'b0, req_reg};
            timer      <= 8'd0;
          end
        end
        HOLD:
          if (!pay_ok && timer != TMAX) timer <= timer + 8'd1;
        CONFIRM: begin
          resp_valid <= 1'b1;
          resp_code  <= RC_OK;
          ticket_id  <= next_id;
          next_id    <= next_id + 8'd1;
        end
        RELEASE: begin
          seats_free <= (release_sum > CAP7) ? CAP : release_sum[5:0];
          resp_valid <= 1'b1;
          resp_code  <= RC_TIMEOUT;
        end
        REJECT: begin
          resp_valid <= 1'b1;
          resp_code  <= rej_code;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ticket_server.sv
// Directed bench for bus_ticket_server with default parameters (40 seats, 16-cycle payment window).
module tb_bus_ticket_server;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_seats = 3'd0;
  logic       req_ready;
  logic       pay_ok = 1'b0;
  logic       cancel_valid = 1'b0;
  logic [2:0] cancel_seats = 3'd0;
  logic       cancel_ack, resp_valid, busy;
  logic [1:0] resp_code;
  logic [7:0] ticket_id;
  logic [5:0] seats_free;

  int checks = 0;
  int errors = 0;

  bus_ticket_server dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_seats(req_seats),
    .req_ready(req_ready), .pay_ok(pay_ok), .cancel_valid(cancel_valid),
    .cancel_seats(cancel_seats), .cancel_ack(cancel_ack), .resp_valid(resp_valid),
    .resp_code(resp_code), .ticket_id(ticket_id), .seats_free(seats_free), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // request accepted, payment on HOLD cycle pay_cycle, confirmation one cycle later
  task automatic confirm(input logic [2:0] n, input int pay_cycle, input logic [7:0] exp_id);
    req_valid = 1'b1; req_seats = n;
    tick();
    req_valid = 1'b0;
    tick();
    repeat (pay_cycle - 1) tick();
    pay_ok = 1'b1;
    tick();
    pay_ok = 1'b0;
    chk("conf_early", 32'(resp_valid), 0);
    tick();
    chk("conf_valid", 32'(resp_valid), 1);
    chk("conf_code", 32'(resp_code), 0);
    chk("conf_id", 32'(ticket_id), 32'(exp_id));
  endtask

  task automatic reject(input logic [2:0] n, input logic [1:0] exp_code, input logic [5:0] exp_free);
    req_valid = 1'b1; req_seats = n;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rej_early", 32'(resp_valid), 0);
    tick();
    chk("rej_valid", 32'(resp_valid), 1);
    chk("rej_code", 32'(resp_code), 32'(exp_code));
    chk("rej_free", 32'(seats_free), 32'(exp_free));
  endtask

  task automatic cancel(input logic [2:0] n, input logic [5:0] exp_free);
    cancel_valid = 1'b1; cancel_seats = n;
    tick();
    cancel_valid = 1'b0;
    chk("cancel_ack", 32'(cancel_ack), 1);
    chk("cancel_noresp", 32'(resp_valid), 0);
    chk("cancel_free", 32'(seats_free), 32'(exp_free));
    tick();
    chk("cancel_ack_drop", 32'(cancel_ack), 0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_free", 32'(seats_free), 40);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_id", 32'(ticket_id), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(req_ready), 1);

    // confirmed bookings; pay on 2nd HOLD cycle first
    confirm(3'd3, 2, 8'd0);
    chk("free_37", 32'(seats_free), 37);
    confirm(3'd4, 1, 8'd1);
    chk("free_33", 32'(seats_free), 33);
    tick();
    chk("resp_pulse", 32'(resp_valid), 0);
    chk("id_hold", 32'(ticket_id), 1);
    confirm(3'd7, 1, 8'd2);
    confirm(3'd7, 3, 8'd3);
    confirm(3'd7, 1, 8'd4);
    confirm(3'd7, 1, 8'd5);
    confirm(3'd3, 1, 8'd6);
    chk("free_2", 32'(seats_free), 2);

    // sold out and invalid
    reject(3'd5, 2'b01, 6'd2);
    reject(3'd0, 2'b11, 6'd2);
    chk("rej_id_hold", 32'(ticket_id), 6);

    // refill, ending with a clamp 39+5 -> 40
    cancel(3'd7, 6'd9);
    cancel(3'd7, 6'd16);
    cancel(3'd7, 6'd23);
    cancel(3'd7, 6'd30);
    cancel(3'd7, 6'd37);
    cancel(3'd2, 6'd39);
    cancel(3'd5, 6'd40);

    // payment timeout at accept+18
    req_valid = 1'b1; req_seats = 3'd4;
    tick();
    req_valid = 1'b0;
    tick();
    chk("to_held", 32'(seats_free), 36);
    repeat (16) tick();
    chk("to_early", 32'(resp_valid), 0);
    chk("to_free_early", 32'(seats_free), 36);
    tick();
    chk("to_valid", 32'(resp_valid), 1);
    chk("to_code", 32'(resp_code), 2);
    chk("to_free", 32'(seats_free), 40);
    pay_ok = 1'b1;
    tick();
    tick();
    pay_ok = 1'b0;
    chk("late_pay_busy", 32'(busy), 0);
    chk("late_pay_resp", 32'(resp_valid), 0);
    chk("late_pay_id", 32'(ticket_id), 6);

    // simultaneous request and cancel: request wins
    req_valid = 1'b1; req_seats = 3'd2;
    cancel_valid = 1'b1; cancel_seats = 3'd3;
    tick();
    req_valid = 1'b0; cancel_valid = 1'b0;
    chk("sim_no_ack", 32'(cancel_ack), 0);
    chk("sim_busy", 32'(busy), 1);
    tick();
    chk("sim_held", 32'(seats_free), 38);
    pay_ok = 1'b1;
    tick();
    pay_ok = 1'b0;
    tick();
    chk("sim_resp", 32'(resp_valid), 1);
    chk("sim_id", 32'(ticket_id), 7);
    cancel(3'd2, 6'd40);
    cancel(3'd0, 6'd40);

    // reset in HOLD discards held seats
    req_valid = 1'b1; req_seats = 3'd5;
    tick();
    req_valid = 1'b0;
    tick();
    chk("hold_free", 32'(seats_free), 35);
    rst = 1'b1;
    tick();
    chk("mid_rst_free", 32'(seats_free), 40);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_resp", 32'(resp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_ready2", 32'(req_ready), 1);
    chk("mid_rst_resp2", 32'(resp_valid), 0);

    // ticket wrap: 256 bookings, then the next gets 0
    for (int i = 0; i < 256; i++) begin
      confirm(3'd1, 1, 8'(i));
      cancel(3'd1, 6'd40);
    end
    confirm(3'd1, 1, 8'd0);
    chk("wrap_free", 32'(seats_free), 39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_ticket_server.md
BUS_TICKET_SERVER -- requirements
Module: bus_ticket_server

Interface
REQ-001 Parameter CAPACITY, default 40, total seats on the bus; legal range 1..63.
REQ-002 Parameter PAY_TIMEOUT, default 16, number of HOLD cycles allowed for payment; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  booking request present.
REQ-006 req_seats  input  3  seats requested; 1..7 are legal, 0 is invalid.
REQ-007 req_ready  output  1  server can accept a request.
REQ-008 pay_ok  input  1  payment confirmation pulse from the app side.
REQ-009 cancel_valid  input  1  cancellation request present.
REQ-010 cancel_seats  input  3  seats returned by the cancellation.
REQ-011 cancel_ack  output  1  one-cycle pulse: cancellation applied.
REQ-012 resp_valid  output  1  one-cycle pulse: booking outcome valid.
REQ-013 resp_code  output  2  outcome: 00 confirmed, 01 sold out, 10 payment timeout, 11 invalid request.
REQ-014 ticket_id  output  8  issued ticket number; meaningful only with resp_code 00.
REQ-015 seats_free  output  6  current unreserved seats.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, CHECK, HOLD, CONFIRM, RELEASE and REJECT.
REQ-018 req_ready SHALL equal (state==IDLE) and SHALL be low while rst is high.
REQ-019 Accept: when req_valid and req_ready are high at an edge, the server SHALL latch req_seats into req_reg and enter CHECK.
REQ-020 CHECK SHALL last one cycle:
  - req_reg==0 -> REJECT with code 11.
  - req_reg>seats_free -> REJECT with code 01.
  - otherwise seats_free-=req_reg (seats held), timer cleared, next state HOLD.
REQ-021 HOLD:
  - pay_ok high -> CONFIRM.
  - else timer==PAY_TIMEOUT-1 -> RELEASE.
  - else timer increments.
REQ-022 pay_ok SHALL be ignored in every state other than HOLD.
REQ-023 CONFIRM SHALL:
  - assert resp_valid with code 00 and ticket_id=next_id for exactly one cycle;
  - increment next_id modulo 256 (255 wraps to 0);
  - return to IDLE.
REQ-024 RELEASE SHALL:
  - add req_reg back to seats_free;
  - assert resp_valid with code 10 for one cycle;
  - return to IDLE.
REQ-025 REJECT SHALL assert resp_valid for one cycle with the code chosen in CHECK, leave seats_free unchanged, and return to IDLE.
REQ-026 Latency SHALL be fixed:
  - reject: resp_valid exactly 2 cycles after the accept edge;
  - confirm: resp_valid 1 cycle after the HOLD edge that sampled pay_ok;
  - timeout: resp_valid PAY_TIMEOUT+2 cycles after the accept edge.
REQ-027 Cancellation SHALL be applied only in IDLE when no request is accepted at the same edge; request acceptance wins a simultaneous event, and cancel_valid is then ignored (the source re-presents it).
REQ-028 An applied cancellation SHALL set seats_free=min(seats_free+cancel_seats, CAPACITY) and pulse cancel_ack for one cycle; cancel_seats==0 still pulses cancel_ack.
REQ-029 seats_free SHALL never exceed CAPACITY nor underflow; the arithmetic SHALL use 7-bit intermediates.
REQ-030 ticket_id SHALL hold its last issued value between confirmations.
REQ-031 resp_valid and cancel_ack SHALL never be high in the same cycle.

Reset
REQ-032 With rst high at an edge, the block SHALL set:
  - state=IDLE, seats_free=CAPACITY;
  - next_id=0, ticket_id=0, timer=0, req_reg=0;
  - resp_valid=0, resp_code=00, cancel_ack=0, busy=0.
REQ-033 Reset asserted mid-operation (CHECK or HOLD) SHALL discard the held seats: seats_free returns to CAPACITY and no resp_valid is issued.
REQ-034 On the first edge after rst falls, req_ready SHALL be high.

Verification
REQ-035 Booking confirmed:
  - stimulus: reset; req_seats=3 accepted; pay_ok on the 2nd HOLD cycle;
  - response: resp_valid code 00, ticket_id=0, seats_free=37; the next booking gets ticket_id=1.
REQ-036 Sold out and invalid request:
  - stimulus: seats_free=2; req_seats=5;
  - response: code 01 two cycles after accept, seats_free stays 2;
  - stimulus: req_seats=0;
  - response: code 11.
REQ-037 Payment timeout:
  - stimulus: req_seats=4; no pay_ok;
  - response: code 10 at accept+18 cycles, seats_free back to 40, pay_ok afterwards ignored.
REQ-038 Cancellation, simultaneous event and clamp:
  - stimulus: req_valid and cancel_valid in the same IDLE cycle;
  - response: request taken, no cancel_ack;
  - stimulus: seats_free=39, cancel_seats=5 in IDLE;
  - response: seats_free=40, cancel_ack pulse.
REQ-039 Reset mid-HOLD and ticket wrap:
  - stimulus: rst in HOLD;
  - response: seats_free=40, no resp_valid;
  - stimulus: 256 confirmed bookings with seats released by cancels;
  - response: the 257th booking gets ticket_id=0.
